// File: rtl/common_dffram_nwmr_if.sv
// Bus bundle for the multi-ported DFF register-file RAM.
// The master drives writes, reads and clear; the slave (the RAM) returns read data.
interface common_dffram_nwmr_if #(
  parameter int DW = 8,  // bits per entry
  parameter int AW = 4,  // address width
  parameter int WP = 2,  // write ports
  parameter int RP = 2   // read ports
);
  logic              clear;
  logic [WP-1:0]     wen;
  logic [WP*AW-1:0]  waddr;
  logic [WP*DW-1:0]  wdata;
  logic [RP-1:0]     ren;
  logic [RP*AW-1:0]  raddr;
  logic [RP*DW-1:0]  rdata;
  logic [RP-1:0]     rvalid;

  modport master (
    output clear, wen, waddr, wdata, ren, raddr,
    input  rdata, rvalid
  );

  modport slave (
    input  clear, wen, waddr, wdata, ren, raddr,
    output rdata, rvalid
  );
endinterface

// File: rtl/common_dffram_nwmr.sv
// DFF-based register-file RAM with N write ports and M read ports.
// Highest-indexed write port wins a collision, clear beats every write,
// optional same-cycle write forwarding and optional registered read data.
module common_dffram_nwmr #(
  parameter int                                   RAM_DATA_WIDTH  = 8,
  parameter int                                   RAM_DEPTH       = 16,
  parameter int                                   WRITE_PORTS     = 2,
  parameter int                                   READ_PORTS      = 2,
  parameter logic [RAM_DEPTH*RAM_DATA_WIDTH-1:0]  RAM_RESET_VALUE = '0,
  parameter bit                                   WRITE_FORWARD   = 1'b0,
  parameter bit                                   READ_REGISTERED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,  // asynchronous, active-low
  common_dffram_nwmr_if.slave  bus
);
  localparam int DW = RAM_DATA_WIDTH;
  localparam int AW = $clog2(RAM_DEPTH);
  // Depth widened by one bit so out-of-range addresses compare correctly
  // even when the depth is an exact power of two.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(RAM_DEPTH);

  logic [DW-1:0]        mem    [RAM_DEPTH];
  logic [RAM_DEPTH-1:0] ent_we;
  logic [DW-1:0]        ent_wd [RAM_DEPTH];
  logic [DW-1:0]        rd_val [READ_PORTS];

  // Per-entry load enable and data; later ports overwrite earlier ones, so the highest port wins.
  // Out-of-range write addresses never equal any entry index and are dropped.
  always_comb begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      ent_we[i] = 1'b0;
      ent_wd[i] = '0;
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (bus.wen[p] && (bus.waddr[p*AW +: AW] == AW'(i))) begin
          ent_we[i] = 1'b1;
          ent_wd[i] = bus.wdata[p*DW +: DW];
        end
      end
    end
  end

  // Storage array: reset and clear both restore the reset image; clear outranks writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: this array is deliberately reset, since the reset image is part of its contract.
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= RAM_RESET_VALUE[DW*i +: DW];
    end else if (bus.clear) begin
      for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= RAM_RESET_VALUE[DW*i +: DW];
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < RAM_DEPTH; i++) begin
        if (ent_we[i]) mem[i] <= ent_wd[i];
      end
    end
  end

  // Unregistered read value: stored entry (zero when out of range), optionally overridden
  // by the collision-winning write data. Clear is never forwarded.
  always_comb begin
    for (int q = 0; q < READ_PORTS; q++) begin
      rd_val[q] = '0;
      if ({1'b0, bus.raddr[q*AW +: AW]} < DEPTH_L) rd_val[q] = mem[bus.raddr[q*AW +: AW]];
      if (WRITE_FORWARD) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (bus.wen[p] &&
              (bus.waddr[p*AW +: AW] == bus.raddr[q*AW +: AW]) &&
              ({1'b0, bus.waddr[p*AW +: AW]} < DEPTH_L)) begin
            rd_val[q] = bus.wdata[p*DW +: DW];
          end
        end
      end
    end
  end

  if (READ_REGISTERED) begin : g_rreg
    logic [DW-1:0]         rdata_q [READ_PORTS];
    logic [READ_PORTS-1:0] rvalid_q;

    // Read capture: data loads only on ren and otherwise holds; rvalid mirrors last-cycle ren.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int q = 0; q < READ_PORTS; q++) rdata_q[q] <= '0;
        rvalid_q <= '0;
      end else begin
        rvalid_q <= bus.ren;
        for (int q = 0; q < READ_PORTS; q++) begin
          if (bus.ren[q]) rdata_q[q] <= rd_val[q];
        end
      end
    end

    // Flatten the per-port registers onto the output bus.
    always_comb begin
      for (int q = 0; q < READ_PORTS; q++) bus.rdata[q*DW +: DW] = rdata_q[q];
    end
    assign bus.rvalid = rvalid_q;
  end else begin : g_rcomb
    // Combinational read: flatten the live read values onto the output bus.
    always_comb begin
      for (int q = 0; q < READ_PORTS; q++) bus.rdata[q*DW +: DW] = rd_val[q];
    end
    assign bus.rvalid = bus.ren;
  end

endmodule

// File: tb/tb_common_dffram_nwmr.sv
// Directed bench for common_dffram_nwmr: three instances cover registered reads
// without and with forwarding (depth 16) and combinational reads at depth 5.
module tb_common_dffram_nwmr;
  localparam logic [127:0] IMG16 = 128'h1F1E_1D1C_1B1A_1918_1716_1514_1312_1110;
  localparam logic [39:0]  IMG5  = 40'h14_1312_1110;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  common_dffram_nwmr_if #(.DW(8), .AW(4), .WP(2), .RP(2)) ia ();
  common_dffram_nwmr_if #(.DW(8), .AW(4), .WP(2), .RP(2)) ib ();
  common_dffram_nwmr_if #(.DW(8), .AW(3), .WP(2), .RP(2)) ic ();

  common_dffram_nwmr #(.RAM_DEPTH(16), .RAM_RESET_VALUE(IMG16),
                       .WRITE_FORWARD(1'b0), .READ_REGISTERED(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  common_dffram_nwmr #(.RAM_DEPTH(16), .RAM_RESET_VALUE(IMG16),
                       .WRITE_FORWARD(1'b1), .READ_REGISTERED(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(ib));
  common_dffram_nwmr #(.RAM_DEPTH(5), .RAM_RESET_VALUE(IMG5),
                       .WRITE_FORWARD(1'b0), .READ_REGISTERED(1'b0))
    dut_c (.clk(clk), .reset(reset), .bus(ic));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive the same stimulus into both depth-16 instances.
  task automatic drv(input logic clr, input logic [1:0] we,
                     input logic [3:0] wa0, input logic [3:0] wa1,
                     input logic [7:0] wd0, input logic [7:0] wd1,
                     input logic [1:0] re, input logic [3:0] ra0, input logic [3:0] ra1);
    ia.clear = clr; ia.wen = we; ia.waddr = {wa1, wa0}; ia.wdata = {wd1, wd0};
    ia.ren = re; ia.raddr = {ra1, ra0};
    ib.clear = clr; ib.wen = we; ib.waddr = {wa1, wa0}; ib.wdata = {wd1, wd0};
    ib.ren = re; ib.raddr = {ra1, ra0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0);
    ic.clear = 1'b0; ic.wen = 2'b00; ic.waddr = '0; ic.wdata = '0;
    ic.ren = 2'b00; ic.raddr = '0;

    // Reset state
    #2;
    check("reset_rdata_a", ia.rdata[7:0], 8'h00);
    check("reset_rvalid_a", {6'b0, ia.rvalid}, 8'h00);
    step();
    step();
    reset = 1'b1;
    step();
    check("post_reset_rvalid_a", {6'b0, ia.rvalid}, 8'h00);

    // Reset image, port 0 ascending and port 1 descending
    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'(i), 4'(15 - i));
      step();
      check("image_p0", ia.rdata[7:0], 8'(8'h10 + i));
      check("image_p1", ia.rdata[15:8], 8'(8'h1F - i));
      check("image_rvalid", {6'b0, ia.rvalid}, 8'h03);
    end

    // Hold with ren low
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0);
    step();
    check("hold_p0", ia.rdata[7:0], 8'h1F);
    check("hold_p1", ia.rdata[15:8], 8'h10);
    check("hold_rvalid", {6'b0, ia.rvalid}, 8'h00);

    // Collision priority: port 1 wins at addr 3
    drv(1'b0, 2'b11, 4'd3, 4'd3, 8'hAA, 8'h55, 2'b00, 4'd0, 4'd0);
    step();
    drv(1'b0, 2'b01, 4'd4, 4'd0, 8'hAA, 8'h00, 2'b01, 4'd3, 4'd0);
    step();
    check("collide_a", ia.rdata[7:0], 8'h55);
    check("collide_b", ib.rdata[7:0], 8'h55);
    check("collide_rvalid", {6'b0, ia.rvalid}, 8'h01);
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd4, 4'd0);
    step();
    check("single_write_a", ia.rdata[7:0], 8'hAA);

    // Forwarding: addr 7 read while written
    drv(1'b0, 2'b01, 4'd7, 4'd0, 8'h3C, 8'h00, 2'b11, 4'd7, 4'd7);
    step();
    check("fwd_off_p0", ia.rdata[7:0], 8'h17);
    check("fwd_on_p0", ib.rdata[7:0], 8'h3C);
    check("fwd_on_p1", ib.rdata[15:8], 8'h3C);
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd7, 4'd0);
    step();
    check("after_fwd_a", ia.rdata[7:0], 8'h3C);
    check("after_fwd_b", ib.rdata[7:0], 8'h3C);

    // Forwarding picks the collision winner
    drv(1'b0, 2'b11, 4'd9, 4'd9, 8'h66, 8'h99, 2'b01, 4'd9, 4'd0);
    step();
    check("fwd_collide_off", ia.rdata[7:0], 8'h19);
    check("fwd_collide_on", ib.rdata[7:0], 8'h99);

    // Clear priority: fill with FF, then clear alongside a write and read of addr 2
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 2'b11, 4'(2 * i), 4'(2 * i + 1), 8'hFF, 8'hFF, 2'b00, 4'd0, 4'd0);
      step();
    end
    drv(1'b1, 2'b01, 4'd2, 4'd0, 8'h01, 8'h00, 2'b01, 4'd2, 4'd0);
    step();
    check("clear_read_a", ia.rdata[7:0], 8'hFF);
    check("clear_read_b", ib.rdata[7:0], 8'h01);
    for (int i = 0; i < 16; i++) begin
      drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b11, 4'(i), 4'(i));
      step();
      check("cleared_a", ia.rdata[7:0], 8'(8'h10 + i));
      check("cleared_b", ib.rdata[15:8], 8'(8'h10 + i));
    end

    // Hold, then asynchronous reset between edges
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd1, 4'd0);
    step();
    check("read1", ia.rdata[7:0], 8'h11);
    check("read1_rvalid", {6'b0, ia.rvalid}, 8'h01);
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0);
    step();
    check("hold1", ia.rdata[7:0], 8'h11);
    check("hold1_rvalid", {6'b0, ia.rvalid}, 8'h00);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_rdata", ia.rdata[7:0], 8'h00);
    reset = 1'b1;

    // Read issued in the edge coincident with reset assertion
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b01, 4'd1, 4'd0);
    step();
    check("reread1", ia.rdata[7:0], 8'h11);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check("coincident_rvalid", {6'b0, ia.rvalid}, 8'h00);
    check("coincident_rdata", ia.rdata[7:0], 8'h00);
    drv(1'b0, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 4'd0, 4'd0);
    #2;
    reset = 1'b1;
    step();
    check("release_rvalid", {6'b0, ia.rvalid}, 8'h00);

    // Depth 5, combinational reads: out-of-range write ignored
    ic.wen = 2'b11; ic.waddr = {3'd6, 3'd6}; ic.wdata = {8'hEE, 8'hDD};
    step();
    ic.wen = 2'b00;
    for (int i = 0; i < 5; i++) begin
      ic.ren = 2'b00; ic.raddr = {3'd0, 3'(i)};
      #1;
      check("d5_unchanged", ic.rdata[7:0], 8'(8'h10 + i));
    end
    ic.ren = 2'b01; ic.raddr = {3'd7, 3'd6};
    #1;
    check("d5_oob_read", ic.rdata[7:0], 8'h00);
    check("d5_oob_read_p1", ic.rdata[15:8], 8'h00);
    check("d5_oob_rvalid", {6'b0, ic.rvalid}, 8'h01);
    ic.wen = 2'b01; ic.waddr = {3'd0, 3'd4}; ic.wdata = {8'h00, 8'h44};
    ic.raddr = {3'd4, 3'd4};
    #1;
    check("d5_addr4_before", ic.rdata[7:0], 8'h14);
    step();
    ic.wen = 2'b00;
    #1;
    check("d5_addr4_after", ic.rdata[15:8], 8'h44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
